wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  2-master -> 1-slave Wishbone classic arbiter sitting directly downstream of the core's
//  instruction (iwbm_*) and data (dwbm_*) master ports; merges them onto one shared memory bus.
//  Registered grant with grant lock for the whole cyc_i burst; selectable fixed/round-robin
//  priority; bus watchdog converts a hung slave into an err_o to the granted master.
// PARAMETERS
//  SEL_W      4   byte-select width on data master and slave port
//  RR_EN      0   0: data master has fixed priority; 1: round-robin (last granted loses ties)
//  TIMEOUT    64  cycles stb may wait for ack/err before forced err; 0 disables watchdog
// PORTS
//  clk_i        in   1      clock, all state on rising edge
//  rst_i        in   1      reset, asynchronous, active-low
//  iwbs_cyc_i   in   1      instruction master cycle
//  iwbs_stb_i   in   1      instruction master strobe
//  iwbs_addr_i  in   32     instruction master address
//  iwbs_dat_o   out  32     read data to instruction master
//  iwbs_ack_o   out  1      ack to instruction master
//  iwbs_err_o   out  1      err to instruction master
//  dwbs_cyc_i   in   1      data master cycle
//  dwbs_stb_i   in   1      data master strobe
//  dwbs_we_i    in   1      data master write enable
//  dwbs_sel_i   in   SEL_W  data master byte select
//  dwbs_addr_i  in   32     data master address
//  dwbs_dat_i   in   32     data master write data
//  dwbs_dat_o   out  32     read data to data master
//  dwbs_ack_o   out  1      ack to data master
//  dwbs_err_o   out  1      err to data master
//  wbm_cyc_o/stb_o/we_o  out 1 each  slave bus controls
//  wbm_sel_o    out  SEL_W  slave byte select (all-ones for instruction master)
//  wbm_addr_o   out  32     slave address
//  wbm_dat_o    out  32     slave write data
//  wbm_dat_i    in   32     slave read data
//  wbm_ack_i    in   1      slave ack
//  wbm_err_i    in   1      slave err
// BEHAVIOUR
//  - FSM states IDLE, GNT_I, GNT_D (registered). Reset (async, rst_i=0): IDLE, wd counter 0,
//    rr pointer = instruction; all wbm_* outputs 0, all ack/err 0 immediately, even mid-cycle.
//  - IDLE: requester = cyc_i high. Next state GNT_D/GNT_I; both requesting: RR_EN=0 -> GNT_D;
//    RR_EN=1 -> master not granted most recently. Grant latency: 1 cycle (req at N, wbm_cyc_o at N+1).
//  - GNT_x: holds while granted cyc_i=1 (lock; other master waits regardless of priority).
//    Granted cyc_i=0: if other master's cyc_i=1, switch directly to its GNT next cycle, else IDLE.
//  - Routing (combinational from state): wbm_cyc_o/stb_o/we_o/sel_o/addr_o/dat_o = granted master's
//    signals; instruction master: we=0, sel all-ones, dat_o=0. IDLE: all wbm_* = 0.
//  - ack/err returned only to granted master (ANDed with its stb_i); other master sees 0.
//    wbm_dat_i fanned to both dat_o ungated.
//  - Watchdog: counter increments each cycle granted cyc&stb=1 and ack_i=err_i=0; clears on ack_i,
//    err_i, stb low or grant change. When count reaches TIMEOUT-1 with no ack: err_o=1 to granted
//    master for that cycle, counter clears. Simultaneous ack_i at the limit: ack wins, no err.
//  - wbm_err_i passed through as err_o; ack_i and err_i both high -> err only.
//  - rr pointer updates on every entry into GNT_I/GNT_D.
// TESTING
//  - Reset: rst_i=0 mid data write -> same cycle wbm_cyc_o=0, dwbs_ack_o=0; after release state IDLE.
//  - Both cyc rise at cycle 0, RR_EN=0 -> cycle 1 wbm_addr_o=dwbs_addr_i, wbm_we_o=dwbs_we_i,
//    iwbs_ack_o stays 0 until dwbs_cyc_i drops, then instr granted next cycle (no IDLE bubble).
//  - RR_EN=1, both masters requesting continuously with 1-cycle cycles -> grants alternate D,I,D,I.
//  - Instr fetch addr 0x8000_0000, slave acks with 0x0000_0013 after 3 cycles -> iwbs_dat_o=0x13,
//    iwbs_ack_o=1 for exactly 1 cycle, wbm_sel_o=4'hF, wbm_we_o=0.
//  - TIMEOUT=8, slave never acks -> dwbs_err_o=1 on 8th stb cycle, one cycle; ack on cycle 8 -> no err.
//  - wbm_err_i=1 during data load -> dwbs_err_o=1, dwbs_ack_o=0, iwbs_err_o=0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone classic arbiter with a registered, burst-locked grant.
// Grant one cycle after cyc_i is seen; the losing master simply waits, and a stalled slave is answered with a forced err.
module wb_arbiter #(
  parameter int SEL_W   = 4,
  parameter bit RR_EN   = 1'b0,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             iwbs_cyc_i,
  input  logic             iwbs_stb_i,
  input  logic [31:0]      iwbs_addr_i,
  output logic [31:0]      iwbs_dat_o,
  output logic             iwbs_ack_o,
  output logic             iwbs_err_o,
  input  logic             dwbs_cyc_i,
  input  logic             dwbs_stb_i,
  input  logic             dwbs_we_i,
  input  logic [SEL_W-1:0] dwbs_sel_i,
  input  logic [31:0]      dwbs_addr_i,
  input  logic [31:0]      dwbs_dat_i,
  output logic [31:0]      dwbs_dat_o,
  output logic             dwbs_ack_o,
  output logic             dwbs_err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [SEL_W-1:0] wbm_sel_o,
  output logic [31:0]      wbm_addr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  input  logic             wbm_err_i
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam int              WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last_d;
  logic [WD_W-1:0] r_wd;
  logic            w_req;
  logic            w_timeout;
  logic            w_ack;
  logic            w_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (dwbs_cyc_i && iwbs_cyc_i)
          w_state_nxt = (RR_EN && r_last_d) ? GNT_I : GNT_D;
        else if (dwbs_cyc_i)
          w_state_nxt = GNT_D;
        else if (iwbs_cyc_i)
          w_state_nxt = GNT_I;
      end
      // Grant is locked for the whole cyc burst; hand over directly without an IDLE bubble.
      GNT_I: if (!iwbs_cyc_i) w_state_nxt = dwbs_cyc_i ? GNT_D : IDLE;
      GNT_D: if (!dwbs_cyc_i) w_state_nxt = iwbs_cyc_i ? GNT_I : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_sel_o  = '0;
    wbm_addr_o = '0;
    wbm_dat_o  = '0;
    case (r_state)
      GNT_I: begin
        wbm_cyc_o  = iwbs_cyc_i;
        wbm_stb_o  = iwbs_stb_i;
        wbm_sel_o  = '1;
        wbm_addr_o = iwbs_addr_i;
      end
      GNT_D: begin
        wbm_cyc_o  = dwbs_cyc_i;
        wbm_stb_o  = dwbs_stb_i;
        wbm_we_o   = dwbs_we_i;
        wbm_sel_o  = dwbs_sel_i;
        wbm_addr_o = dwbs_addr_i;
        wbm_dat_o  = dwbs_dat_i;
      end
      default: ;
    endcase
  end

  assign w_req     = wbm_cyc_o & wbm_stb_o;
  assign w_timeout = (TIMEOUT != 0) && w_req && !wbm_ack_i && !wbm_err_i && (r_wd == WD_LIM);
  // A slave err suppresses a coincident ack.
  assign w_ack     = wbm_stb_o & wbm_ack_i & ~wbm_err_i;
  assign w_err     = wbm_stb_o & (wbm_err_i | w_timeout);

  assign iwbs_dat_o = wbm_dat_i;
  assign dwbs_dat_o = wbm_dat_i;
  assign iwbs_ack_o = (r_state == GNT_I) & w_ack;
  assign iwbs_err_o = (r_state == GNT_I) & w_err;
  assign dwbs_ack_o = (r_state == GNT_D) & w_ack;
  assign dwbs_err_o = (r_state == GNT_D) & w_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_wd     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state && w_state_nxt != IDLE)
        r_last_d <= (w_state_nxt == GNT_D);
      if (w_state_nxt != r_state || !w_req || wbm_ack_i || wbm_err_i || w_timeout)
        r_wd <= '0;
      else
        r_wd <= r_wd + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: fixed-priority instance with an 8-cycle watchdog plus a round-robin instance.
module tb_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        iwbs_cyc_i, iwbs_stb_i;
  logic [31:0] iwbs_addr_i;
  logic        dwbs_cyc_i, dwbs_stb_i, dwbs_we_i;
  logic [3:0]  dwbs_sel_i;
  logic [31:0] dwbs_addr_i, dwbs_dat_i;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i;

  logic [31:0] fx_iwbs_dat_o, fx_dwbs_dat_o, fx_wbm_addr_o, fx_wbm_dat_o;
  logic        fx_iwbs_ack_o, fx_iwbs_err_o, fx_dwbs_ack_o, fx_dwbs_err_o;
  logic        fx_wbm_cyc_o, fx_wbm_stb_o, fx_wbm_we_o;
  logic [3:0]  fx_wbm_sel_o;
  logic [31:0] rr_iwbs_dat_o, rr_dwbs_dat_o, rr_wbm_addr_o, rr_wbm_dat_o;
  logic        rr_iwbs_ack_o, rr_iwbs_err_o, rr_dwbs_ack_o, rr_dwbs_err_o;
  logic        rr_wbm_cyc_o, rr_wbm_stb_o, rr_wbm_we_o;
  logic [3:0]  rr_wbm_sel_o;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        is_d;
    logic        err;
    logic [31:0] dat;
  } resp_t;
  resp_t exp_q[$];

  always #5 clk_i = ~clk_i;

  wb_arbiter #(.SEL_W(4), .RR_EN(1'b0), .TIMEOUT(8)) u_fix (
    .clk_i(clk_i), .rst_i(rst_i),
    .iwbs_cyc_i(iwbs_cyc_i), .iwbs_stb_i(iwbs_stb_i), .iwbs_addr_i(iwbs_addr_i),
    .iwbs_dat_o(fx_iwbs_dat_o), .iwbs_ack_o(fx_iwbs_ack_o), .iwbs_err_o(fx_iwbs_err_o),
    .dwbs_cyc_i(dwbs_cyc_i), .dwbs_stb_i(dwbs_stb_i), .dwbs_we_i(dwbs_we_i),
    .dwbs_sel_i(dwbs_sel_i), .dwbs_addr_i(dwbs_addr_i), .dwbs_dat_i(dwbs_dat_i),
    .dwbs_dat_o(fx_dwbs_dat_o), .dwbs_ack_o(fx_dwbs_ack_o), .dwbs_err_o(fx_dwbs_err_o),
    .wbm_cyc_o(fx_wbm_cyc_o), .wbm_stb_o(fx_wbm_stb_o), .wbm_we_o(fx_wbm_we_o),
    .wbm_sel_o(fx_wbm_sel_o), .wbm_addr_o(fx_wbm_addr_o), .wbm_dat_o(fx_wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  wb_arbiter #(.SEL_W(4), .RR_EN(1'b1), .TIMEOUT(0)) u_rr (
    .clk_i(clk_i), .rst_i(rst_i),
    .iwbs_cyc_i(iwbs_cyc_i), .iwbs_stb_i(iwbs_stb_i), .iwbs_addr_i(iwbs_addr_i),
    .iwbs_dat_o(rr_iwbs_dat_o), .iwbs_ack_o(rr_iwbs_ack_o), .iwbs_err_o(rr_iwbs_err_o),
    .dwbs_cyc_i(dwbs_cyc_i), .dwbs_stb_i(dwbs_stb_i), .dwbs_we_i(dwbs_we_i),
    .dwbs_sel_i(dwbs_sel_i), .dwbs_addr_i(dwbs_addr_i), .dwbs_dat_i(dwbs_dat_i),
    .dwbs_dat_o(rr_dwbs_dat_o), .dwbs_ack_o(rr_dwbs_ack_o), .dwbs_err_o(rr_dwbs_err_o),
    .wbm_cyc_o(rr_wbm_cyc_o), .wbm_stb_o(rr_wbm_stb_o), .wbm_we_o(rr_wbm_we_o),
    .wbm_sel_o(rr_wbm_sel_o), .wbm_addr_o(rr_wbm_addr_o), .wbm_dat_o(rr_wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic is_d, input logic err, input logic [31:0] dat);
    exp_q.push_back({is_d, err, dat});
  endtask

  task automatic drop_all();
    iwbs_cyc_i = 1'b0; iwbs_stb_i = 1'b0;
    dwbs_cyc_i = 1'b0; dwbs_stb_i = 1'b0;
    wbm_ack_i  = 1'b0; wbm_err_i  = 1'b0;
  endtask

  // Every ack/err seen by a master of the fixed instance must match the oldest queued expectation.
  always @(negedge clk_i) begin
    logic  i_any, d_any;
    resp_t e;
    i_any = fx_iwbs_ack_o | fx_iwbs_err_o;
    d_any = fx_dwbs_ack_o | fx_dwbs_err_o;
    if (i_any || d_any) begin
      chk("resp_one_master", 32'(i_any & d_any), 32'd0);
      chk("resp_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("resp_master", 32'(d_any), 32'(e.is_d));
        chk("resp_err", 32'(fx_iwbs_err_o | fx_dwbs_err_o), 32'(e.err));
        if (!e.err) chk("resp_dat", d_any ? fx_dwbs_dat_o : fx_iwbs_dat_o, e.dat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_i = 1'b0;
    drop_all();
    iwbs_addr_i = '0; dwbs_we_i = 1'b1; dwbs_sel_i = 4'hC;
    dwbs_addr_i = 32'h44; dwbs_dat_i = 32'hFFFF_FFFF; wbm_dat_i = '0;
    dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1;

    // Requests held during reset must not reach the slave.
    @(negedge clk_i);
    chk("rst_cyc", 32'(fx_wbm_cyc_o), 32'd0);
    chk("rst_addr", fx_wbm_addr_o, 32'd0);
    tick();
    @(negedge clk_i);
    chk("rst_stb", 32'(fx_wbm_stb_o), 32'd0);
    drop_all();
    tick();
    rst_i = 1'b1;
    tick();

    // Instruction fetch, slave answers on the third strobe cycle.
    iwbs_cyc_i = 1'b1; iwbs_stb_i = 1'b1; iwbs_addr_i = 32'h8000_0000;
    @(negedge clk_i);
    chk("gnt_latency", 32'(fx_wbm_cyc_o), 32'd0);
    tick();
    @(negedge clk_i);
    chk("i_cyc", 32'(fx_wbm_cyc_o), 32'd1);
    chk("i_addr", fx_wbm_addr_o, 32'h8000_0000);
    chk("i_sel", 32'(fx_wbm_sel_o), 32'hF);
    chk("i_we", 32'(fx_wbm_we_o), 32'd0);
    chk("i_wdat", fx_wbm_dat_o, 32'd0);
    tick();
    tick();
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h0000_0013;
    push(1'b0, 1'b0, 32'h0000_0013);
    @(negedge clk_i);
    chk("i_dat", fx_iwbs_dat_o, 32'h0000_0013);
    tick();
    wbm_ack_i = 1'b0;
    @(negedge clk_i);
    chk("i_ack_1cyc", 32'(fx_iwbs_ack_o), 32'd0);
    tick();
    drop_all();
    tick();
    tick();

    // Both request together: data wins, instruction waits and is handed the bus directly.
    dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1; dwbs_we_i = 1'b1; dwbs_sel_i = 4'h3;
    dwbs_addr_i = 32'h1000; dwbs_dat_i = 32'hDEAD_BEEF;
    iwbs_cyc_i = 1'b1; iwbs_stb_i = 1'b1; iwbs_addr_i = 32'h100;
    tick();
    @(negedge clk_i);
    chk("d_addr", fx_wbm_addr_o, 32'h1000);
    chk("d_we", 32'(fx_wbm_we_o), 32'd1);
    chk("d_sel", 32'(fx_wbm_sel_o), 32'h3);
    chk("d_wdat", fx_wbm_dat_o, 32'hDEAD_BEEF);
    tick();
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h55;
    push(1'b1, 1'b0, 32'h55);
    @(negedge clk_i);
    chk("i_locked_out", 32'(fx_iwbs_ack_o), 32'd0);
    tick();
    wbm_ack_i = 1'b0; dwbs_cyc_i = 1'b0; dwbs_stb_i = 1'b0;
    @(negedge clk_i);
    chk("hold_d_route", fx_wbm_addr_o, 32'h1000);
    tick();
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h77;
    push(1'b0, 1'b0, 32'h77);
    @(negedge clk_i);
    chk("no_bubble_cyc", 32'(fx_wbm_cyc_o), 32'd1);
    chk("no_bubble_addr", fx_wbm_addr_o, 32'h100);
    tick();
    drop_all();
    tick();
    tick();

    // Slave error on a data load, with a coincident ack that must be suppressed.
    dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1; dwbs_we_i = 1'b0; dwbs_addr_i = 32'h2000;
    tick();
    wbm_err_i = 1'b1; wbm_ack_i = 1'b1;
    push(1'b1, 1'b1, 32'd0);
    @(negedge clk_i);
    chk("err_d", 32'(fx_dwbs_err_o), 32'd1);
    chk("err_no_ack", 32'(fx_dwbs_ack_o), 32'd0);
    chk("err_not_i", 32'(fx_iwbs_err_o), 32'd0);
    tick();
    drop_all();
    tick();
    tick();

    // Slave never answers: forced err on the 8th strobe cycle only.
    dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1; dwbs_addr_i = 32'h3000;
    push(1'b1, 1'b1, 32'd0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      @(negedge clk_i);
      chk($sformatf("wd_err_c%0d", k), 32'(fx_dwbs_err_o), 32'(k == 8));
      if (k == 8) chk("wd_disabled", 32'(rr_dwbs_err_o), 32'd0);
    end
    drop_all();
    tick();
    tick();

    // Ack arriving exactly at the limit beats the watchdog.
    dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 8) begin
        wbm_ack_i = 1'b1; wbm_dat_i = 32'hA5;
        push(1'b1, 1'b0, 32'hA5);
      end
      @(negedge clk_i);
      chk($sformatf("wd_ack_wins_c%0d", k), 32'(fx_dwbs_err_o), 32'd0);
    end
    tick();
    drop_all();
    tick();
    tick();

    // Reset asserted mid data write silences the bus within the same cycle.
    dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1; dwbs_we_i = 1'b1; dwbs_addr_i = 32'h4000;
    tick();
    @(negedge clk_i);
    chk("pre_rst_cyc", 32'(fx_wbm_cyc_o), 32'd1);
    tick();
    wbm_ack_i = 1'b1;
    #2;
    rst_i = 1'b0;
    #1;
    chk("midrst_cyc", 32'(fx_wbm_cyc_o), 32'd0);
    chk("midrst_ack", 32'(fx_dwbs_ack_o), 32'd0);
    chk("midrst_we", 32'(fx_wbm_we_o), 32'd0);
    drop_all();
    iwbs_cyc_i = 1'b1; iwbs_stb_i = 1'b1; iwbs_addr_i = 32'h500;
    tick();
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("post_rst_idle", 32'(fx_wbm_cyc_o), 32'd0);
    tick();
    @(negedge clk_i);
    chk("post_rst_gnt", fx_wbm_addr_o, 32'h500);
    tick();
    drop_all();
    tick();
    tick();

    // Repeated simultaneous requests from idle: round-robin alternates D,I,D,I; fixed always D.
    for (int r = 0; r < 4; r++) begin
      iwbs_cyc_i = 1'b1; iwbs_stb_i = 1'b1; iwbs_addr_i = 32'h600 + 32'(r);
      dwbs_cyc_i = 1'b1; dwbs_stb_i = 1'b1; dwbs_addr_i = 32'h700 + 32'(r);
      tick();
      wbm_ack_i = 1'b1; wbm_dat_i = 32'h100 + 32'(r);
      push(1'b1, 1'b0, 32'h100 + 32'(r));
      @(negedge clk_i);
      chk($sformatf("rr_d_r%0d", r), 32'(rr_dwbs_ack_o), 32'(r % 2 == 0));
      chk($sformatf("rr_i_r%0d", r), 32'(rr_iwbs_ack_o), 32'(r % 2 == 1));
      tick();
      drop_all();
      tick();
    end

    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
